apb_master_arb: RTL and testbench
=================================

// Module: apb_master_arb
// PURPOSE
//  Shares one AMBA3 APB master port between NUM_REQ internal requesters (config/status agents of the aligner).
//  Round-robin arbitrates single-beat read/write commands, sequences APB SETUP/ACCESS phases, waits on pready,
//  returns prdata/pslverr to the granted requester. A pready timeout guards against a hung slave.
// PARAMETERS
//  NUM_REQ  2   number of requesters (>=1)
//  ADDR_W   16  APB paddr width
//  DATA_W   32  APB pwdata/prdata width
//  TIMEOUT  16  max ACCESS cycles with pready=0 before forced error; 0 disables timeout
// PORTS
//  pclk       in   1               APB clock, all logic on rising edge
//  preset_n   in   1               asynchronous active-low reset
//  req_valid  in   NUM_REQ         command pending per requester
//  req_ready  out  NUM_REQ         command accepted (one-hot, comb, 1-cycle pulse)
//  req_write  in   NUM_REQ         1=write 0=read, per requester
//  req_addr   in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W  packed write data, same packing
//  rsp_valid  out  NUM_REQ         one-hot registered completion pulse to owning requester
//  rsp_rdata  out  DATA_W          read data, valid with rsp_valid (0 for writes/timeouts)
//  rsp_err    out  1               pslverr or timeout, valid with rsp_valid
//  busy       out  1               state != IDLE
//  psel/penable/pwrite  out  1     APB control
//  paddr      out  ADDR_W          APB address
//  pwdata     out  DATA_W          APB write data
//  prdata     in   DATA_W          APB read data
//  pready     in   1               APB slave ready
//  pslverr    in   1               APB slave error
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer=0 (req 0 highest priority first), timeout count 0; in-flight cmd dropped, no rsp.
//  Arbitration point: state IDLE, or ACCESS with pready=1 (or timeout expiry). Winner = first req_valid at/after rr pointer,
//   wrapping; req_ready[winner]=1 that cycle; cmd (write,addr,wdata,index) registered; rr pointer <= winner+1 mod NUM_REQ.
//  FSM IDLE -> SETUP on grant. SETUP: psel=1 penable=0, one cycle -> ACCESS. ACCESS: psel=1 penable=1, paddr/pwrite/pwdata stable.
//  ACCESS & pready: rsp_valid[idx]<=1, rsp_rdata<=pwrite?0:prdata, rsp_err<=pslverr (next cycle, one-cycle pulse);
//   then SETUP if a new grant made same cycle (psel stays 1, penable->0), else IDLE (psel->0).
//  Min throughput: 2 cycles/transfer back-to-back; latency req_ready -> rsp_valid = 3 cycles with zero wait states.
//  Timeout: counter increments each ACCESS cycle with pready=0, clears on entering SETUP. When count==TIMEOUT-1 and pready=0:
//   complete with rsp_err=1, rsp_rdata=0, drop psel/penable (IDLE, or SETUP if new grant). pready on the expiry cycle wins (normal completion).
//  Requester must hold req_valid/cmd until req_ready; requester may re-request in the cycle its rsp_valid is high.
//  req_valid deasserting while not granted: no effect. All APB outputs registered; no X on paddr/pwdata after reset.
//  Arithmetic: timeout counter width $clog2(TIMEOUT+1); rr pointer width $clog2(NUM_REQ) (1 bit min), wrap explicit.
// STRUCTURE
//  Package apb_ctrl_pkg: typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_e; APB_ADDR_W=16, APB_DATA_W=32.
//  Sub-module rr_arbiter #(N): inputs req[N], ptr, en; outputs grant one-hot, grant_idx. Pure comb; pointer update in top.
//  Top holds FSM, cmd registers, timeout counter, response registers.
// TESTING
//  Single write, req0 addr 0x0010 data 0xDEADBEEF, pready=1 -> SETUP then ACCESS one cycle each, rsp_valid[0] pulse, rsp_err=0.
//  Read req1 addr 0x0024, slave pready after 3 wait cycles, prdata 0x12345678 -> psel/penable held 4 ACCESS cycles, rsp_rdata 0x12345678.
//  req0,req1 continuously valid, NUM_REQ=2 -> grants alternate 0,1,0,1; psel never drops; 2 cycles per transfer.
//  Slave pready=0 forever, TIMEOUT=16 -> exactly 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, psel=0 next cycle.
//  pslverr=1 with pready on write addr 0xFFFC -> rsp_err=1 on owning requester only.
//  preset_n low mid-ACCESS -> psel/penable/rsp_valid 0 asynchronously; after release, req1 only valid -> granted, rr restarts at 0.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// Shared types and default widths for the APB master arbiter.
package apb_ctrl_pkg;
  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);
  logic found;

  // Two passes: upper segment [ptr..N-1] first, then the wrapped lower segment.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i] && (i >= int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (en && !found && req[i] && (i < int'(ptr))) begin
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
        found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/apb_master_arb.sv
// Shares one APB master port between NUM_REQ requesters with round-robin
// arbitration, SETUP/ACCESS sequencing and a pready timeout.
//
//   state      | meaning
//   APB_IDLE   | no transfer; arbitrate every cycle
//   APB_SETUP  | psel=1 penable=0, one cycle
//   APB_ACCESS | psel=1 penable=1 until pready or timeout; re-arbitrate on exit
module apb_master_arb
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  apb_state_e         state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, grant_idx, cmd_idx;
  logic [NUM_REQ-1:0] grant;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               tmo_hit, xfer_done, arb_en;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // pready on the expiry cycle takes precedence over the timeout.
  assign tmo_hit   = (TIMEOUT != 0) && (state == APB_ACCESS) && !pready && (tmo_cnt == TMO_LAST);
  assign xfer_done = (state == APB_ACCESS) && (pready || tmo_hit);
  assign arb_en    = (state == APB_IDLE) || xfer_done;
  assign req_ready = grant;
  assign busy      = (state != APB_IDLE);

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      APB_IDLE:   if (|grant) state_nxt = APB_SETUP;
      APB_SETUP:  state_nxt = APB_ACCESS;
      APB_ACCESS: if (xfer_done) state_nxt = (|grant) ? APB_SETUP : APB_IDLE;
      default:    state_nxt = APB_IDLE;
    endcase
  end

  // paddr/pwrite/pwdata double as the registered command.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state   <= APB_IDLE;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
      cmd_idx <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      state   <= state_nxt;
      psel    <= (state_nxt != APB_IDLE);
      penable <= (state_nxt == APB_ACCESS);
      tmo_cnt <= ((state == APB_ACCESS) && !pready) ? tmo_cnt + CNT_W'(1) : '0;
      if (|grant) begin
        cmd_idx <= grant_idx;
        pwrite  <= sel_write;
        paddr   <= sel_addr;
        pwdata  <= sel_wdata;
        rr_ptr  <= (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (xfer_done) begin
        for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] <= (cmd_idx == PTR_W'(i));
        rsp_rdata <= (pwrite || tmo_hit) ? '0 : prdata;
        rsp_err   <= tmo_hit || pslverr;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_arb.sv
// Scoreboard bench for apb_master_arb: queued requesters, wait-state APB slave,
// transaction-level reference model of arbitration, memory, errors and timeouts.
module tb_apb_master_arb;
  localparam int N   = 2;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic            pclk, preset_n;
  logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata;
  logic [AW-1:0]   paddr;
  logic            rsp_err, busy, psel, penable, pwrite, pready, pslverr;

  apb_master_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset_n(preset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct { bit w; logic [15:0] a; logic [31:0] d; int waits; } cmd_t;
  typedef struct { logic [31:0] d; bit e; } exp_t;

  cmd_t cq [N][$];
  exp_t eq [N][$];
  int   wq [$];
  logic [31:0] ref_mem [logic [15:0]];
  logic [31:0] smem    [logic [15:0]];

  int checks = 0, passed = 0;
  int cyc = 0, mptr = 0;
  int gc [$];
  int gw [$];
  int last_grant_cyc = 0, last_rsp_cyc = 0, acc_n = 0, setup_n = 0, last_setup = 0;
  int cur_w = 0, psel_drops = 0;
  bit in_acc = 0, watch_psel = 0, rsp_psel = 0;
  logic [31:0]  last_rdata = '0;
  logic [N-1:0] last_rsp_vec = '0;

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
  endtask

  task automatic enq(input int i, input bit w, input logic [15:0] a, input logic [31:0] d, input int waits);
    cmd_t c;
    c.w = w; c.a = a; c.d = d; c.waits = waits;
    cq[i].push_back(c);
  endtask

  task automatic wait_done(input int budget, input string nm);
    int k = 0;
    while (k < budget && !(cq[0].size() == 0 && cq[1].size() == 0 &&
                           eq[0].size() == 0 && eq[1].size() == 0)) begin
      @(posedge pclk);
      k++;
    end
    chk({nm, "_done"}, 64'(k < budget), 64'(1));
    repeat (2) @(posedge pclk);
  endtask

  task automatic wait_grants(input int n, input int budget, input string nm);
    int k = 0;
    while (k < budget && gc.size() < n) begin
      @(posedge pclk);
      k++;
    end
    chk({nm, "_granted"}, 64'(k < budget), 64'(1));
  endtask

  always @(posedge pclk) cyc++;

  // Requester driver plus arbitration/reference model at each accepted command.
  always begin : drv
    logic [N-1:0] gm, egm;
    int w, ew, j;
    cmd_t c;
    exp_t e;
    @(negedge pclk);
    gm = req_ready;
    if (preset_n && gm != '0) begin
      ew = -1;
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (ew < 0 && req_valid[j]) ew = j;
      end
      egm = '0;
      if (ew >= 0) egm[ew] = 1'b1;
      chk("grant_vector", 64'(gm), 64'(egm));
      w = 0;
      for (int k = N - 1; k >= 0; k--) if (gm[k]) w = k;
      if (cq[w].size() == 0) begin
        chk("grant_without_request", 64'(gm), 64'(0));
      end else begin
        c = cq[w][0];
        if (c.waits >= TMO) begin
          e.d = '0; e.e = 1'b1;
        end else begin
          e.e = (c.a >= 16'hFFF0);
          if (c.w) begin
            e.d = '0;
            if (!e.e) ref_mem[c.a] = c.d;
          end else begin
            e.d = ref_mem.exists(c.a) ? ref_mem[c.a] : dflt(c.a);
          end
        end
        eq[w].push_back(e);
        wq.push_back(c.waits);
      end
      mptr = (w + 1) % N;
      gc.push_back(cyc);
      gw.push_back(w);
      last_grant_cyc = cyc;
    end
    @(posedge pclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (gm[i] && cq[i].size() > 0) cq[i].delete(0);
      if (cq[i].size() > 0) begin
        req_valid[i]             = 1'b1;
        req_write[i]             = cq[i][0].w;
        req_addr[i*AW +: AW]     = cq[i][0].a;
        req_wdata[i*DW +: DW]    = cq[i][0].d;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  end

  // APB slave: per-transfer wait states from wq, memory, error above 0xFFF0.
  always begin : slave
    @(posedge pclk);
    #1;
    if (preset_n && psel && penable) begin
      if (!in_acc) begin
        in_acc     = 1'b1;
        acc_n      = 0;
        last_setup = setup_n;
        setup_n    = 0;
        cur_w      = (wq.size() > 0) ? wq.pop_front() : 0;
      end
      acc_n++;
      if (cur_w == 0) begin
        pready  = 1'b1;
        pslverr = (paddr >= 16'hFFF0);
        prdata  = pwrite ? $urandom : (smem.exists(paddr) ? smem[paddr] : dflt(paddr));
        if (pwrite && !pslverr) smem[paddr] = pwdata;
      end else begin
        cur_w--;
        pready  = 1'($urandom);
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = $urandom;
      end
    end else begin
      in_acc = 1'b0;
      if (preset_n && psel) setup_n++;
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
    end
  end

  // Response monitor: pops the owning requester's expectation.
  always @(negedge pclk) begin : mon
    exp_t e;
    if (preset_n && watch_psel && !psel) psel_drops++;
    if (preset_n && rsp_valid != '0) begin
      chk("rsp_onehot", 64'($countones(rsp_valid)), 64'(1));
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          if (eq[i].size() == 0) begin
            chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
          end else begin
            e = eq[i].pop_front();
            chk($sformatf("rsp_rdata_req%0d", i), 64'(rsp_rdata), 64'(e.d));
            chk($sformatf("rsp_err_req%0d", i), 64'(rsp_err), 64'(e.e));
          end
        end
      end
      last_rsp_cyc = cyc;
      rsp_psel     = psel;
      last_rdata   = rsp_rdata;
      last_rsp_vec = rsp_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int a_sel;
    preset_n  = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_ctrl", 64'({psel, penable, pwrite, busy}), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    chk("rst_pwdata", 64'(pwdata), 64'(0));
    chk("rst_rsp", 64'({rsp_valid, rsp_err, rsp_rdata}), 64'(0));
    @(negedge pclk);
    preset_n = 1'b1;

    enq(0, 1'b1, 16'h0010, 32'hDEADBEEF, 0);
    wait_done(50, "t1");
    chk("t1_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'(3));
    chk("t1_setup_cycles", 64'(last_setup), 64'(1));
    chk("t1_access_cycles", 64'(acc_n), 64'(1));
    enq(0, 1'b0, 16'h0010, 32'h0, 1);
    wait_done(50, "t1_readback");

    smem[16'h0024]    = 32'h12345678;
    ref_mem[16'h0024] = 32'h12345678;
    enq(1, 1'b0, 16'h0024, 32'h0, 3);
    wait_done(50, "t2");
    chk("t2_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'(6));
    chk("t2_access_cycles", 64'(acc_n), 64'(4));
    chk("t2_rdata", 64'(last_rdata), 64'h12345678);

    gc.delete();
    gw.delete();
    for (int k = 0; k < 6; k++) begin
      enq(0, 1'b1, 16'(16'h0100 + 4 * k), $urandom, 0);
      enq(1, 1'b0, 16'(16'h0100 + 4 * k), 32'h0, 0);
    end
    wait_grants(1, 50, "t3_first");
    #2 watch_psel = 1'b1;
    wait_grants(12, 100, "t3_all");
    @(negedge pclk);
    @(negedge pclk);
    #1 watch_psel = 1'b0;
    wait_done(100, "t3");
    chk("t3_psel_drops", 64'(psel_drops), 64'(0));
    chk("t3_first_winner", 64'(gw[0]), 64'(0));
    for (int k = 1; k < 12; k++)
      chk($sformatf("t3_spacing_%0d", k), 64'(gc[k] - gc[k-1]), 64'(2));

    enq(0, 1'b0, 16'h0300, 32'h0, 1000);
    wait_done(100, "t4");
    chk("t4_latency", 64'(last_rsp_cyc - last_grant_cyc), 64'(18));
    chk("t4_access_cycles", 64'(acc_n), 64'(TMO));
    chk("t4_psel_after", 64'(rsp_psel), 64'(0));
    enq(1, 1'b0, 16'h0024, 32'h0, TMO - 1);
    wait_done(100, "t4b");
    chk("t4b_access_cycles", 64'(acc_n), 64'(TMO));
    chk("t4b_rdata", 64'(last_rdata), 64'h12345678);

    enq(1, 1'b1, 16'hFFFC, 32'h0BAD0BAD, 0);
    wait_done(50, "t5");
    chk("t5_owner", 64'(last_rsp_vec), 64'(2'b10));
    enq(1, 1'b0, 16'hFFFC, 32'h0, 0);
    wait_done(50, "t5_readback");

    gc.delete();
    gw.delete();
    enq(0, 1'b0, 16'h0100, 32'h0, 10);
    wait_grants(1, 50, "t6_inflight");
    repeat (3) @(posedge pclk);
    #3;
    preset_n = 1'b0;
    #1;
    chk("t6_async_clear", 64'({psel, penable, rsp_valid, busy}), 64'(0));
    for (int i = 0; i < N; i++) begin
      cq[i].delete();
      eq[i].delete();
    end
    wq.delete();
    mptr      = 0;
    req_valid = '0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
    gc.delete();
    gw.delete();
    enq(0, 1'b0, 16'h0104, 32'h0, 0);
    enq(1, 1'b0, 16'h0108, 32'h0, 0);
    wait_done(50, "t6_both");
    enq(1, 1'b1, 16'h010C, 32'hCAFE0001, 0);
    wait_done(50, "t6_req1");
    chk("t6_rr_restart", 64'(gw[0]), 64'(0));
    chk("t6_req1_only", 64'(gw[gw.size() - 1]), 64'(1));

    for (int n = 0; n < 120; n++) begin
      a_sel = $urandom_range(0, 15);
      enq($urandom_range(0, 1), 1'($urandom_range(0, 1)),
          (a_sel == 0) ? 16'hFFF4 : 16'(16'h0400 + 4 * $urandom_range(0, 7)),
          $urandom,
          ($urandom_range(0, 19) == 0) ? 30 : $urandom_range(0, 3));
    end
    wait_done(8000, "t7_random");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
